// File: rtl/vm_change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: coin values, FSM states, error codes.
package vm_change_dispenser_pkg;

  // Default coin values, largest first
  localparam int unsigned DefDenom0 = 100;
  localparam int unsigned DefDenom1 = 25;
  localparam int unsigned DefDenom2 = 10;
  localparam int unsigned DefDenom3 = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StWaitRel,
    StDone,
    StErr
  } vm_state_e;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrNoChange = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  function automatic logic [3:0] hop_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vm_hopper_stock.sv
// Per-hopper coin stock: saturating counter with refill (+REFILL_QTY) and take (-1).
module vm_hopper_stock #(
  parameter int unsigned STK_W      = 8,
  parameter int unsigned INIT_STOCK = 20,
  parameter int unsigned REFILL_QTY = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill,
  input  logic             take,
  output logic [STK_W-1:0] count,
  output logic             empty
);

  localparam logic [STK_W:0] CntMax = {1'b0, {STK_W{1'b1}}};

  logic [STK_W-1:0] count_q, count_d;
  logic [STK_W:0]   sum;

  // Net change computed one bit wider so the refill saturation is visible
  always_comb begin
    sum = {1'b0, count_q};
    if (refill) sum = sum + (STK_W+1)'(REFILL_QTY);
    if (take && (sum != '0)) sum = sum - (STK_W+1)'(1);
    count_d = (sum > CntMax) ? {STK_W{1'b1}} : sum[STK_W-1:0];
  end

  // Stock register, reloaded with the initial fill on reset
  always_ff @(posedge clk) begin
    if (rst) count_q <= STK_W'(INIT_STOCK);
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: greedy coin split, one req/ack handshake per coin, per-hopper stock.
module vm_change_dispenser
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned AMT_W       = 10,
  parameter int unsigned DENOM_0     = DefDenom0,
  parameter int unsigned DENOM_1     = DefDenom1,
  parameter int unsigned DENOM_2     = DefDenom2,
  parameter int unsigned DENOM_3     = DefDenom3,
  parameter int unsigned STK_W       = 8,
  parameter int unsigned INIT_STOCK  = 20,
  parameter int unsigned REFILL_QTY  = 50,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_change,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [AMT_W-1:0] o_remaining,
  output logic [3:0]       o_hop_req,
  input  logic [3:0]       i_hop_ack,
  input  logic [3:0]       i_refill,
  output logic [3:0]       o_stock_empty
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [AMT_W-1:0] Denom [4] = '{AMT_W'(DENOM_0), AMT_W'(DENOM_1),
                                             AMT_W'(DENOM_2), AMT_W'(DENOM_3)};

  vm_state_e        state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       sel_q, sel_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       hop_req_q, hop_req_d;

  logic [STK_W-1:0] stock [4];
  logic [3:0]       take;
  logic             found;
  logic [1:0]       pick;

  for (genvar g = 0; g < 4; g++) begin : gen_hop
    vm_hopper_stock #(
      .STK_W      (STK_W),
      .INIT_STOCK (INIT_STOCK),
      .REFILL_QTY (REFILL_QTY)
    ) u_stock (
      .clk    (i_clk),
      .rst    (i_rst),
      .refill (i_refill[g]),
      .take   (take[g]),
      .count  (stock[g]),
      .empty  (o_stock_empty[g])
    );
  end

  // Greedy pick: largest coin that fits the remainder and is in stock
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && (Denom[k] <= rem_q) && (stock[k] != '0)) begin
        found = 1'b1;
        pick  = 2'(k);
      end
    end
  end

  // Next state, payout arithmetic and registered-output next values
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    tmr_d      = tmr_q;
    err_code_d = err_code_q;
    take       = '0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          rem_d      = i_change;
          err_code_d = ErrNone;
          state_d    = StSelect;
        end
      end
      StSelect: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (!found) begin
          err_code_d = ErrNoChange;
          state_d    = StErr;
        end else if (i_hop_ack == '0) begin
          // A lingering ack from any hopper holds us here before a new request
          sel_d   = pick;
          tmr_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (i_hop_ack[sel_q]) begin
          rem_d       = rem_q - Denom[sel_q];
          take[sel_q] = 1'b1;
          state_d     = StWaitRel;
        end else if (tmr_q == TmrLast) begin
          err_code_d = ErrTimeout;
          state_d    = StErr;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWaitRel: begin
        if (!i_hop_ack[sel_q]) state_d = StSelect;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    hop_req_d = (state_d == StReq) ? hop_onehot(sel_d) : 4'b0000;
    // Done/err pulse the cycle after the DONE/ERR state; busy covers that pulse too
    done_d    = (state_q == StDone);
    err_d     = (state_q == StErr);
    busy_d    = (state_d != StIdle) || (state_q == StDone) || (state_q == StErr);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      sel_q      <= 2'd0;
      tmr_q      <= '0;
      err_code_q <= ErrNone;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hop_req_q  <= 4'b0000;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      tmr_q      <= tmr_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hop_req_q  <= hop_req_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_remaining = rem_q;
  assign o_hop_req   = hop_req_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser: greedy model predicts coin order, outcome and stock.
module tb_vm_change_dispenser;

  localparam int AckDly  = 3;
  localparam int RelDly  = 2;
  localparam int Budget  = 2000;
  localparam int Refill  = 50;
  localparam int StkMax  = 255;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [9:0] i_change;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;
  logic [9:0] o_remaining;
  logic [3:0] o_hop_req;
  logic [3:0] i_hop_ack;
  logic [3:0] i_refill;
  logic [3:0] o_stock_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int model_stk [4];
  int denoms [4] = '{100, 25, 10, 5};
  int exp_hop_q [$];

  always #5 i_clk = ~i_clk;

  vm_change_dispenser dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_change      (i_change),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_err_code    (o_err_code),
    .o_remaining   (o_remaining),
    .o_hop_req     (o_hop_req),
    .i_hop_ack     (i_hop_ack),
    .i_refill      (i_refill),
    .o_stock_empty (o_stock_empty)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int stock_of(input int k);
    case (k)
      0:       return int'(dut.stock[0]);
      1:       return int'(dut.stock[1]);
      2:       return int'(dut.stock[2]);
      default: return int'(dut.stock[3]);
    endcase
  endfunction

  task automatic check_stocks();
    int empty_exp = 0;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("stock%0d", k), stock_of(k), model_stk[k]);
      if (model_stk[k] == 0) empty_exp |= (1 << k);
    end
    check_val("stock_empty", int'(o_stock_empty), empty_exp);
  endtask

  // One payout: model predicts, bench plays the hoppers, scoreboard checks each request.
  // stall_hop never acks; refill_hop gets a refill pulse on its first ack; inject pulses start mid-run.
  task automatic do_payout(input int amt, input int stall_hop, input int refill_hop, input bit inject);
    int  rem = amt;
    bit  exp_done = 1'b1;
    int  exp_code = 0;
    bit  m_refilled = 1'b0;
    bit  rf_done = 1'b0;
    bit  finished = 1'b0;
    bit  got_done = 1'b0;
    bit  got_err = 1'b0;
    int  phase = 0;
    int  cnt = 0;
    int  cur = 0;
    int  req_cycles = 0;
    int  first_req_j = -1;
    int  end_j = -1;
    while (rem != 0) begin
      int k;
      k = -1;
      for (int d = 0; d < 4; d++)
        if (k < 0 && denoms[d] <= rem && model_stk[d] > 0) k = d;
      if (k < 0) begin
        exp_done = 1'b0; exp_code = 1;
        break;
      end
      exp_hop_q.push_back(k);
      if (k == stall_hop) begin
        exp_done = 1'b0; exp_code = 2;
        break;
      end
      model_stk[k] = model_stk[k] - 1;
      if (k == refill_hop && !m_refilled) begin
        m_refilled = 1'b1;
        model_stk[k] = model_stk[k] + Refill;
        if (model_stk[k] > StkMax) model_stk[k] = StkMax;
      end
      rem = rem - denoms[k];
    end

    @(negedge i_clk);
    i_start  = 1'b1;
    i_change = 10'(amt);
    for (int j = 1; j <= Budget && !finished; j++) begin
      @(negedge i_clk);
      i_start  = 1'b0;
      i_refill = '0;
      if (inject && j == 4) begin
        i_start  = 1'b1;
        i_change = 10'd5;
      end
      if (j == 1) check_val("busy_after_start", int'(o_busy), 1);
      if (o_done || o_err) begin
        finished = 1'b1;
        got_done = o_done;
        got_err  = o_err;
        end_j    = j;
      end else if (phase == 0) begin
        if (o_hop_req != '0) begin
          if (first_req_j < 0) first_req_j = j;
          check_val("hop_onehot", $countones(o_hop_req), 1);
          for (int b = 0; b < 4; b++) if (o_hop_req[b]) cur = b;
          if (exp_hop_q.size() == 0) check_val("hop_extra", cur, -1);
          else check_val("hop_seq", cur, exp_hop_q.pop_front());
          cnt = 0;
          req_cycles = 1;
          phase = (cur == stall_hop) ? 4 : 1;
        end
      end else if (phase == 1) begin
        cnt++;
        if (cnt == AckDly) begin
          i_hop_ack[cur] = 1'b1;
          if (cur == refill_hop && !rf_done) begin
            i_refill[cur] = 1'b1;
            rf_done = 1'b1;
          end
          phase = 2;
        end
      end else if (phase == 2) begin
        if (o_hop_req == '0) begin
          cnt = 0;
          phase = 3;
        end
      end else if (phase == 3) begin
        cnt++;
        if (cnt == RelDly) begin
          i_hop_ack[cur] = 1'b0;
          phase = 0;
        end
      end else begin
        if (o_hop_req != '0) req_cycles++;
      end
    end
    i_start   = 1'b0;
    i_refill  = '0;
    i_hop_ack = '0;
    if (!finished) check_val("cycle_bound", 0, 1);
    check_val("done", int'(got_done), int'(exp_done));
    check_val("err", int'(got_err), int'(!exp_done));
    check_val("err_code", int'(o_err_code), exp_code);
    check_val("remaining", int'(o_remaining), rem);
    check_val("hops_left", exp_hop_q.size(), 0);
    if (first_req_j >= 0) check_val("req_latency", first_req_j, 2);
    if (amt == 0) check_val("zero_done_latency", end_j, 3);
    if (stall_hop >= 0 && phase == 4) check_val("timeout_len", req_cycles, 1000);
    exp_hop_q.delete();
    @(negedge i_clk);
    check_val("busy_after_end", int'(o_busy), 0);
    check_val("pulse_width", int'(o_done | o_err), 0);
    check_stocks();
  endtask

  initial begin
    bit got_req;
    i_rst = 1'b1; i_start = 1'b0; i_change = '0; i_hop_ack = '0; i_refill = '0;
    for (int k = 0; k < 4; k++) model_stk[k] = 20;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_val("rst_busy", int'(o_busy), 0);
    check_val("rst_done", int'(o_done), 0);
    check_val("rst_err", int'(o_err), 0);
    check_val("rst_err_code", int'(o_err_code), 0);
    check_val("rst_remaining", int'(o_remaining), 0);
    check_val("rst_hop_req", int'(o_hop_req), 0);
    check_stocks();

    // 85 from full stock: 25,25,25,10
    do_payout(85, -1, -1, 1'b0);
    check_val("t85_stock1", stock_of(1), 17);
    check_val("t85_stock2", stock_of(2), 19);

    // Bring hopper 1 down to one coin, then 85 pays 25 + six 10s
    repeat (5) do_payout(75, -1, -1, 1'b0);
    do_payout(25, -1, -1, 1'b0);
    check_val("pre_stock1", stock_of(1), 1);
    do_payout(85, -1, -1, 1'b0);
    check_val("t85b_remaining", int'(o_remaining), 0);

    // Empty hopper 3; 30 then comes out as three 10s
    repeat (20) do_payout(5, -1, -1, 1'b0);
    do_payout(30, -1, -1, 1'b0);
    // Empty hopper 2; 30 now has no exact change
    repeat (10) do_payout(10, -1, -1, 1'b0);
    do_payout(30, -1, -1, 1'b0);
    check_val("t30_err_code", int'(o_err_code), 1);
    check_val("t30_remaining", int'(o_remaining), 30);

    // Hopper 0 never acks
    do_payout(100, 0, -1, 1'b0);
    check_val("tmo_err_code", int'(o_err_code), 2);
    check_val("tmo_remaining", int'(o_remaining), 100);
    check_val("tmo_stock0", stock_of(0), 20);

    // Reset while a request of a 150 payout is outstanding
    @(negedge i_clk);
    i_start = 1'b1; i_change = 10'd150;
    @(negedge i_clk);
    i_start = 1'b0;
    got_req = 1'b0;
    for (int j = 0; j < 20 && !got_req; j++) begin
      @(negedge i_clk);
      if (o_hop_req != '0) got_req = 1'b1;
    end
    check_val("rst_mid_req_seen", int'(got_req), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check_val("rst_mid_hop_req", int'(o_hop_req), 0);
    check_val("rst_mid_busy", int'(o_busy), 0);
    check_val("rst_mid_remaining", int'(o_remaining), 0);
    for (int k = 0; k < 4; k++) model_stk[k] = 20;
    check_stocks();

    // Zero change right after reset: no request, done 3 cycles after start
    do_payout(0, -1, -1, 1'b0);
    // Refill of hopper 1 together with its ack, plus a start pulse while busy
    do_payout(25, -1, 1, 1'b1);
    check_val("refill_stock1", stock_of(1), 69);
    check_val("inject_remaining", int'(o_remaining), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
